uart_rx_ctrl: RTL and testbench

Receive sequencer for the UART serial input. It generates the oversample tick from the system clock and validates the start bit. It samples each data bit at mid-bit, checks the stop bit, and hands each completed byte to the consumer over a valid/ready interface. It sits between the `rx` pad and the byte consumer (FIFO or register file) and reports sticky framing and overrun errors.

---
 rtl/uart_rx_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive sequencer for the UART serial input.
//   Synchronizes rx_in, derives the oversample tick from clk, checks the start
//   bit at mid-bit, samples each data bit at mid-bit, checks the stop bit and
//   hands the byte to the consumer over a valid/ready interface.
// Ports:
//   clk, rst          - system clock, synchronous active-high reset
//   rx_in             - asynchronous serial line (idles high)
//   enable            - allows a new frame to start
//   data_out/valid    - received byte (LSB first on the wire) and its valid flag
//   data_ready        - consumer accepts the byte when data_valid is 1
//   rx_busy           - FSM not in IDLE
//   frame_err         - sticky: stop bit sampled low
//   overrun_err       - sticky: byte dropped because data_valid was still held
//   err_clr           - one-cycle pulse clearing both sticky errors
module uart_rx_ctrl #(
  parameter int CLK_DIV    = 27,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  input  logic                 enable,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 overrun_err,
  input  logic                 err_clr
);

  localparam logic [15:0] TICK_MAX = 16'(CLK_DIV - 1);
  localparam logic [6:0]  HALF_M1  = 7'(OVERSAMPLE / 2 - 1);
  localparam logic [6:0]  FULL_M1  = 7'(OVERSAMPLE - 1);
  localparam logic [2:0]  BIT_MAX  = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_e;

  state_e                 state_q, state_d;
  logic                   rx_s1_q, rxs_q;
  logic [15:0]            tick_cnt_q, tick_cnt_d;
  logic [6:0]             samp_cnt_q, samp_cnt_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   deliver_q, deliver_d;
  logic [DATA_BITS-1:0]   data_out_q, data_out_d;
  logic                   data_valid_q, data_valid_d;
  logic                   rx_busy_q, rx_busy_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_err_q, overrun_err_d;
  logic                   tick, frame_set, overrun_set;

  assign tick = (tick_cnt_q == TICK_MAX);

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick ? 16'd0 : tick_cnt_q + 16'd1;
    samp_cnt_d  = samp_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    deliver_d   = 1'b0;
    frame_set   = 1'b0;
    overrun_set = 1'b0;
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;

    case (state_q)
      S_IDLE: begin
        if (enable && !rxs_q) begin
          state_d    = S_START;
          // Restart the tick phase at the start edge so every sample lands mid-bit.
          tick_cnt_d = 16'd0;
          samp_cnt_d = 7'd0;
          bit_cnt_d  = 3'd0;
        end
      end
      S_START: begin
        if (tick) begin
          if (samp_cnt_q == HALF_M1) begin
            samp_cnt_d = 7'd0;
            state_d    = rxs_q ? S_IDLE : S_DATA;
          end else begin
            samp_cnt_d = samp_cnt_q + 7'd1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          if (samp_cnt_q == FULL_M1) begin
            samp_cnt_d = 7'd0;
            shift_d    = {rxs_q, shift_q[DATA_BITS-1:1]};
            if (bit_cnt_q == BIT_MAX) begin
              bit_cnt_d = 3'd0;
              state_d   = S_STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end else begin
            samp_cnt_d = samp_cnt_q + 7'd1;
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          if (samp_cnt_q == FULL_M1) begin
            samp_cnt_d = 7'd0;
            if (rxs_q) begin
              deliver_d = 1'b1;
              state_d   = S_IDLE;
            end else begin
              frame_set = 1'b1;
              state_d   = S_BREAK;
            end
          end else begin
            samp_cnt_d = samp_cnt_q + 7'd1;
          end
        end
      end
      S_BREAK: begin
        // A held-low line must not be mistaken for a stream of start bits.
        if (rxs_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // shift_q is stable during the deliver cycle: the next frame's first data
    // sample is at least half a bit away.
    if (deliver_q) begin
      if (!data_valid_q || data_ready) begin
        data_out_d   = shift_q;
        data_valid_d = 1'b1;
      end else begin
        overrun_set = 1'b1;
      end
    end else if (data_valid_q && data_ready) begin
      data_valid_d = 1'b0;
    end

    rx_busy_d     = (state_d != S_IDLE);
    // Set beats clear when both happen in the same cycle.
    frame_err_d   = frame_set   | (frame_err_q   & ~err_clr);
    overrun_err_d = overrun_set | (overrun_err_q & ~err_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      rx_s1_q       <= 1'b1;
      rxs_q         <= 1'b1;
      tick_cnt_q    <= 16'd0;
      samp_cnt_q    <= 7'd0;
      bit_cnt_q     <= 3'd0;
      shift_q       <= '0;
      deliver_q     <= 1'b0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      rx_busy_q     <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rx_s1_q       <= rx_in;
      rxs_q         <= rx_s1_q;
      tick_cnt_q    <= tick_cnt_d;
      samp_cnt_q    <= samp_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      deliver_q     <= deliver_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      rx_busy_q     <= rx_busy_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign rx_busy     = rx_busy_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with CLK_DIV=4, OVERSAMPLE=16, DATA_BITS=8
// (one bit = 64 clk). Inputs change 1 time unit after the rising edge; a
// negedge monitor counts valid/busy cycles and logs every accepted byte.
module tb_uart_rx_ctrl;
  logic       clk = 1'b0;
  logic       rst, rx_in, enable, data_ready, err_clr;
  logic [7:0] data_out;
  logic       data_valid, rx_busy, frame_err, overrun_err;

  int n_checks = 0;
  int n_fail   = 0;
  int vcnt     = 0;
  int busy_cnt = 0;
  logic [7:0] acc[$];

  uart_rx_ctrl #(.CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .enable(enable),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
    .rx_busy(rx_busy), .frame_err(frame_err), .overrun_err(overrun_err),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (data_valid) vcnt++;
    if (rx_busy) busy_cnt++;
    if (data_valid && data_ready) acc.push_back(data_out);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One 640-clk frame; err_clr pulses at frame cycle clr_at (-1: never).
  task automatic send_frame(input logic [7:0] b, input logic stop, input int clr_at);
    for (int idx = 0; idx < 640; idx++) begin
      if (idx < 64)       rx_in = 1'b0;
      else if (idx < 576) rx_in = b[(idx - 64) / 64];
      else                rx_in = stop;
      err_clr = (idx == clr_at);
      step(1);
    end
    err_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_in = 1'b1; enable = 1'b1; data_ready = 1'b1; err_clr = 1'b0;
    step(3);
    rst = 1'b0;
    n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data_out got %h want 00", data_out); end
    n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", data_valid); end
    n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", rx_busy); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
    n_checks++; if (overrun_err !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b want 0", overrun_err); end
    step(5);
  endtask

  task automatic test_single_frame();
    int v0 = vcnt;
    int a0 = acc.size();
    send_frame(8'hA5, 1'b1, -1);
    step(10);
    n_checks++; if (acc.size() - a0 !== 1) begin n_fail++; $display("FAIL a5_count got %0d want 1", acc.size() - a0); end
    else begin
      n_checks++; if (acc[a0] !== 8'hA5) begin n_fail++; $display("FAIL a5_data got %h want a5", acc[a0]); end
    end
    n_checks++; if (vcnt - v0 !== 1) begin n_fail++; $display("FAIL a5_valid_cycles got %0d want 1", vcnt - v0); end
    n_checks++; if (data_out !== 8'hA5) begin n_fail++; $display("FAIL a5_hold got %h want a5", data_out); end
    n_checks++; if (frame_err !== 1'b0 || overrun_err !== 1'b0) begin n_fail++; $display("FAIL a5_errs got %b%b want 00", frame_err, overrun_err); end
    n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL a5_busy got %b want 0", rx_busy); end
  endtask

  task automatic test_glitch();
    int b0 = busy_cnt;
    int v0 = vcnt;
    rx_in = 1'b0;
    step(20);
    rx_in = 1'b1;
    step(80);
    // busy from 3 clk after the edge (2 sync + FSM) until the start check 32 clk later
    n_checks++; if (busy_cnt - b0 !== 32) begin n_fail++; $display("FAIL glitch_busy_cycles got %0d want 32", busy_cnt - b0); end
    n_checks++; if (vcnt - v0 !== 0) begin n_fail++; $display("FAIL glitch_valid got %0d want 0", vcnt - v0); end
    n_checks++; if (frame_err !== 1'b0 || overrun_err !== 1'b0) begin n_fail++; $display("FAIL glitch_errs got %b%b want 00", frame_err, overrun_err); end
  endtask

  task automatic test_frame_err();
    int v0 = vcnt;
    send_frame(8'h3C, 1'b0, -1);
    step(200);
    n_checks++; if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL break_busy got %b want 1", rx_busy); end
    rx_in = 1'b1;
    step(100);
    n_checks++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL ferr_set got %b want 1", frame_err); end
    n_checks++; if (vcnt - v0 !== 0) begin n_fail++; $display("FAIL ferr_valid got %0d want 0", vcnt - v0); end
    n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL ferr_idle got %b want 0", rx_busy); end
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL ferr_clr got %b want 0", frame_err); end
  endtask

  task automatic test_overrun();
    int a0 = acc.size();
    data_ready = 1'b0;
    send_frame(8'h11, 1'b1, -1);
    send_frame(8'h22, 1'b1, -1);
    step(10);
    n_checks++; if (data_out !== 8'h11) begin n_fail++; $display("FAIL ovr_data got %h want 11", data_out); end
    n_checks++; if (data_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid got %b want 1", data_valid); end
    n_checks++; if (overrun_err !== 1'b1) begin n_fail++; $display("FAIL ovr_flag got %b want 1", overrun_err); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL ovr_ferr got %b want 0", frame_err); end
    data_ready = 1'b1;
    step(1);
    data_ready = 1'b0;
    n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_consume got %b want 0", data_valid); end
    n_checks++; if (acc.size() - a0 !== 1) begin n_fail++; $display("FAIL ovr_accepted got %0d want 1", acc.size() - a0); end
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    data_ready = 1'b1;
    n_checks++; if (overrun_err !== 1'b0) begin n_fail++; $display("FAIL ovr_clr got %b want 0", overrun_err); end
  endtask

  task automatic test_rst_mid_frame();
    int v0 = vcnt;
    int a0;
    logic [7:0] b = 8'h99; // bit 4 is 1, so releasing the line after reset makes no edge
    for (int idx = 0; idx < 340; idx++) begin
      rx_in = (idx < 64) ? 1'b0 : b[(idx - 64) / 64];
      step(1);
    end
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    rx_in = 1'b1;
    n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL rst_data_out got %h want 00", data_out); end
    n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", rx_busy); end
    n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", data_valid); end
    step(400);
    n_checks++; if (vcnt - v0 !== 0) begin n_fail++; $display("FAIL rst_no_delivery got %0d want 0", vcnt - v0); end
    a0 = acc.size();
    send_frame(8'h5A, 1'b1, -1);
    step(10);
    n_checks++; if (acc.size() - a0 !== 1) begin n_fail++; $display("FAIL rst_next_count got %0d want 1", acc.size() - a0); end
    else begin
      n_checks++; if (acc[a0] !== 8'h5A) begin n_fail++; $display("FAIL rst_next_data got %h want 5a", acc[a0]); end
    end
  endtask

  task automatic test_enable_gate();
    int b0 = busy_cnt;
    int v0 = vcnt;
    enable = 1'b0;
    send_frame(8'h77, 1'b1, -1);
    step(10);
    enable = 1'b1;
    n_checks++; if (busy_cnt - b0 !== 0 || vcnt - v0 !== 0) begin n_fail++; $display("FAIL enable_gate got busy %0d valid %0d want 0 0", busy_cnt - b0, vcnt - v0); end
  endtask

  task automatic test_back_to_back();
    int v0 = vcnt;
    int a0 = acc.size();
    send_frame(8'h00, 1'b1, -1);
    send_frame(8'hFF, 1'b1, -1);
    step(10);
    n_checks++; if (vcnt - v0 !== 2) begin n_fail++; $display("FAIL b2b_valid_cycles got %0d want 2", vcnt - v0); end
    n_checks++; if (acc.size() - a0 !== 2) begin n_fail++; $display("FAIL b2b_count got %0d want 2", acc.size() - a0); end
    else begin
      n_checks++; if (acc[a0] !== 8'h00 || acc[a0+1] !== 8'hFF) begin n_fail++; $display("FAIL b2b_data got %h %h want 00 ff", acc[a0], acc[a0+1]); end
    end
    n_checks++; if (frame_err !== 1'b0 || overrun_err !== 1'b0) begin n_fail++; $display("FAIL b2b_errs got %b%b want 00", frame_err, overrun_err); end
    // Stop sample lands 611 clk after the frame's first cycle; err_clr must be
    // high in the cycle feeding that edge (frame cycle 610).
    send_frame(8'h00, 1'b0, 610);
    step(5);
    n_checks++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL set_beats_clr got %b want 1", frame_err); end
    rx_in = 1'b1;
    step(20);
    n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL break_exit got %b want 0", rx_busy); end
  endtask

  initial begin
    fork
      begin
        test_reset();
        test_single_frame();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_rst_mid_frame();
        test_enable_gate();
        test_back_to_back();
      end
      begin
        #2000000;
        n_checks++;
        n_fail++;
        $display("FAIL timeout got no completion want completion");
      end
    join_any
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
